// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential signed divider.
// The state encoding and the iteration counter width live here.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  function automatic int div_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_div_ctrl.sv
// Divider sequencer: the IDLE/RUN/FIX state machine and the iteration counter.
// It decodes busy and the load/iterate/fix enables for the datapath in the top.
module seq_div_ctrl
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic zero_div,
  output logic busy,
  output logic load_en,
  output logic iter_en,
  output logic fix_en
);

  localparam int            CW   = div_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t    state_r;
  div_state_t    state_nx;
  logic [CW-1:0] cnt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx;
      if (load_en) begin
        cnt_r <= '0;
      end else if (iter_en) begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx = zero_div ? FIX : RUN;
        end
      end
      RUN: begin
        if (cnt_r == LAST) begin
          state_nx = FIX;
        end
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_r == RUN) || (state_r == FIX);
    load_en = (state_r == IDLE) && start;
    iter_en = (state_r == RUN);
    fix_en  = (state_r == FIX);
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential truncating signed divider: radix-2 non-restoring on magnitudes, then sign fix-up.
// Optional SEQ_DIV_UNSIGNED_EN adds an is_signed input selecting unsigned operation per start.
module seq_signed_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHECK_PARAM = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SEQ_DIV_UNSIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  if (CHECK_PARAM != 0 && WIDTH < 2) begin : g_param_chk
    $fatal(1, "seq_signed_divider: WIDTH must be at least 2");
  end

  logic sgn_mode;
`ifdef SEQ_DIV_UNSIGNED_EN
  assign sgn_mode = is_signed;
`else
  assign sgn_mode = 1'b1;
`endif

  // Two's complement negate when sel is set; MIN wraps onto itself.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic sel);
    return sel ? (-v) : v;
  endfunction

  logic load_en;
  logic iter_en;
  logic fix_en;
  logic zero_div;

  assign zero_div = (divisor == '0);

  seq_div_ctrl #(
    .WIDTH(WIDTH)
  ) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .zero_div(zero_div),
    .busy    (busy),
    .load_en (load_en),
    .iter_en (iter_en),
    .fix_en  (fix_en)
  );

  logic                    sign_a;
  logic                    sign_b;
  logic [WIDTH-1:0]        q_r;
  logic [WIDTH-1:0]        d_r;
  logic signed [WIDTH:0]   p_r;
  logic                    neg_q_r;
  logic                    neg_r_r;
  logic                    dbz_r;

  logic signed [WIDTH:0]   d_ext;
  logic signed [WIDTH:0]   p_sh;
  logic signed [WIDTH:0]   p_nx;
  logic [WIDTH-1:0]        rem_mag;
  logic [WIDTH-1:0]        quot_fix;
  logic [WIDTH-1:0]        rem_fix;

  assign sign_a = sgn_mode & dividend[WIDTH-1];
  assign sign_b = sgn_mode & divisor[WIDTH-1];

  // Non-restoring step: shift {P,Q}, subtract or add |divisor| by the sign of the old P.
  assign d_ext = $signed({1'b0, d_r});
  assign p_sh  = $signed({p_r[WIDTH-1:0], q_r[WIDTH-1]});
  assign p_nx  = p_r[WIDTH] ? (p_sh + d_ext) : (p_sh - d_ext);

  // A negative final remainder needs one restoring add; divide-by-zero reports the dividend.
  assign rem_mag  = dbz_r ? q_r
                  : (p_r[WIDTH] ? (p_r[WIDTH-1:0] + d_r) : p_r[WIDTH-1:0]);
  assign quot_fix = dbz_r ? '1 : cond_neg(q_r, neg_q_r);
  assign rem_fix  = cond_neg(rem_mag, neg_r_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r     <= '0;
      d_r     <= '0;
      p_r     <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dbz_r   <= 1'b0;
    end else if (load_en) begin
      q_r     <= cond_neg(dividend, sign_a);
      d_r     <= cond_neg(divisor, sign_b);
      p_r     <= '0;
      neg_q_r <= sign_a ^ sign_b;
      neg_r_r <= sign_a;
      dbz_r   <= zero_div;
    end else if (iter_en) begin
      p_r <= p_nx;
      q_r <= {q_r[WIDTH-2:0], ~p_nx[WIDTH]};
    end
  end

  // Result registers only change on the fix cycle, so a reset or busy start never leaks partials.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= fix_en;
      if (fix_en) begin
        quotient    <= quot_fix;
        remainder   <= rem_fix;
        div_by_zero <= dbz_r;
      end
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider (WIDTH=8) against a plain-arithmetic reference.
module tb_seq_signed_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_signed_divider #(
    .WIDTH(W),
    .CHECK_PARAM(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
`ifdef SEQ_DIV_UNSIGNED_EN
    .is_signed  (1'b1),
`endif
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // C-style truncating division on plain integers.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output int lat);
    int sa, sb, iq, ir;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) begin
      q = '1; r = a; z = 1'b1; lat = 1;
    end else begin
      iq = sa / sb;
      ir = sa % sb;
      q = iq[W-1:0]; r = ir[W-1:0]; z = 1'b0; lat = W + 1;
    end
  endfunction

  // Called at posedge+1; returns after the sampling edge, again at posedge+1.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = busy ? 1 : 0;
    while (1) begin
      @(posedge clk); #1;
      edges++;
      if (done) break;
      if (busy) busy_cnt++;
      if (edges > 40) break;
    end
  endtask

  task automatic test_reset;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (quotient !== '0) begin n_bad++; $display("FAIL reset_q got=%h want=00", quotient); end
    n_cmp++; if (remainder !== '0) begin n_bad++; $display("FAIL reset_r got=%h want=00", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [8] = '{8'd100, 8'h9C, 8'd100, 8'd7, 8'd9, 8'h80, 8'd127, 8'd5};
    logic [W-1:0] tb [8] = '{8'd7,   8'd7,  8'hF9,  8'd0, 8'd3, 8'hFF, 8'd127, 8'd9};
    logic [W-1:0] eq, er;
    logic ez;
    int lat, edges, bcnt;
    for (int i = 0; i < 8; i++) begin
      ref_div(ta[i], tb[i], eq, er, ez, lat);
      launch(ta[i], tb[i]);
      wait_done(edges, bcnt);
      n_cmp++; if (edges !== lat) begin n_bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, edges, lat); end
      n_cmp++; if (bcnt !== lat) begin n_bad++; $display("FAIL dir%0d_busy_cycles got=%0d want=%0d", i, bcnt, lat); end
      n_cmp++; if (quotient !== eq) begin n_bad++; $display("FAIL dir%0d_q got=%h want=%h", i, quotient, eq); end
      n_cmp++; if (remainder !== er) begin n_bad++; $display("FAIL dir%0d_r got=%h want=%h", i, remainder, er); end
      n_cmp++; if (div_by_zero !== ez) begin n_bad++; $display("FAIL dir%0d_dbz got=%b want=%b", i, div_by_zero, ez); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL dir%0d_done_pulse got=%b want=0", i, done); end
      n_cmp++; if (quotient !== eq) begin n_bad++; $display("FAIL dir%0d_q_hold got=%h want=%h", i, quotient, eq); end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, eq, er;
    logic ez;
    int lat, edges, bcnt, sel;
    for (int i = 0; i < 150; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) b = '0;
      else if (sel == 1) b = 8'hFF;
      else if (sel == 2) a = 8'h80;
      else if (sel == 3) b = 8'h80;
      ref_div(a, b, eq, er, ez, lat);
      launch(a, b);
      wait_done(edges, bcnt);
      n_cmp++; if (edges !== lat) begin n_bad++; $display("FAIL rnd_latency a=%h b=%h got=%0d want=%0d", a, b, edges, lat); end
      n_cmp++; if (quotient !== eq) begin n_bad++; $display("FAIL rnd_q a=%h b=%h got=%h want=%h", a, b, quotient, eq); end
      n_cmp++; if (remainder !== er) begin n_bad++; $display("FAIL rnd_r a=%h b=%h got=%h want=%h", a, b, remainder, er); end
      n_cmp++; if (div_by_zero !== ez) begin n_bad++; $display("FAIL rnd_dbz a=%h b=%h got=%b want=%b", a, b, div_by_zero, ez); end
    end
  endtask

  task automatic test_start_while_busy;
    logic [W-1:0] eq, er;
    logic ez;
    int lat, edges, bcnt;
    ref_div(8'd100, 8'd7, eq, er, ez, lat);
    launch(8'd100, 8'd7);
    repeat (3) begin @(posedge clk); #1; end
    launch(8'd50, 8'd0);
    dividend = 8'd33;
    divisor  = 8'd2;
    wait_done(edges, bcnt);
    n_cmp++; if (edges + 4 !== lat) begin n_bad++; $display("FAIL busy_start_latency got=%0d want=%0d", edges + 4, lat); end
    n_cmp++; if (quotient !== eq) begin n_bad++; $display("FAIL busy_start_q got=%h want=%h", quotient, eq); end
    n_cmp++; if (remainder !== er) begin n_bad++; $display("FAIL busy_start_r got=%h want=%h", remainder, er); end
    n_cmp++; if (div_by_zero !== ez) begin n_bad++; $display("FAIL busy_start_dbz got=%b want=%b", div_by_zero, ez); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] q1, r1, q2, r2;
    logic z1, z2;
    int lat1, lat2, edges, bcnt;
    ref_div(8'h9C, 8'd7, q1, r1, z1, lat1);
    ref_div(8'd77, 8'hF6, q2, r2, z2, lat2);
    launch(8'h9C, 8'd7);
    wait_done(edges, bcnt);
    n_cmp++; if (quotient !== q1 || remainder !== r1) begin n_bad++; $display("FAIL b2b_first got=%h/%h want=%h/%h", quotient, remainder, q1, r1); end
    launch(8'd77, 8'hF6);
    n_cmp++; if (quotient !== q1 || remainder !== r1) begin n_bad++; $display("FAIL b2b_hold got=%h/%h want=%h/%h", quotient, remainder, q1, r1); end
    wait_done(edges, bcnt);
    n_cmp++; if (edges !== lat2) begin n_bad++; $display("FAIL b2b_latency got=%0d want=%0d", edges, lat2); end
    n_cmp++; if (quotient !== q2 || remainder !== r2 || div_by_zero !== z2) begin
      n_bad++; $display("FAIL b2b_second got=%h/%h/%b want=%h/%h/%b", quotient, remainder, div_by_zero, q2, r2, z2);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] eq, er;
    logic ez;
    int lat, edges, bcnt;
    launch(8'd90, 8'd4);
    wait_done(edges, bcnt);
    launch(8'd120, 8'd11);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got=%b want=0", done); end
    n_cmp++; if (quotient !== '0 || remainder !== '0) begin n_bad++; $display("FAIL midrst_outputs got=%h/%h want=00/00", quotient, remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL midrst_dbz got=%b want=0", div_by_zero); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0 || quotient !== '0) begin n_bad++; $display("FAIL midrst_no_partial done=%b q=%h want 0 00", done, quotient); end
    ref_div(8'hE3, 8'd5, eq, er, ez, lat);
    launch(8'hE3, 8'd5);
    wait_done(edges, bcnt);
    n_cmp++; if (edges !== lat) begin n_bad++; $display("FAIL postrst_latency got=%0d want=%0d", edges, lat); end
    n_cmp++; if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
      n_bad++; $display("FAIL postrst_result got=%h/%h/%b want=%h/%h/%b", quotient, remainder, div_by_zero, eq, er, ez);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
